if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0000: instruction word presented when the IF/ID register is invalid.
REQ-003 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port stall, input, 1 bit: decode cannot accept; hold the PC and IF/ID contents.
REQ-006 SHALL have port redirect_valid, input, 1 bit: taken branch or jump from a later stage.
REQ-007 SHALL have port redirect_pc, input, 32 bits: target byte address.
REQ-008 SHALL have port rom_addr, output, 32 bits: byte address to the synchronous instruction ROM (one-cycle read latency).
REQ-009 SHALL have port rom_instr, input, 32 bits: ROM data, valid one cycle after its address.
REQ-010 SHALL have port ifid_valid, output, 1 bit: IF/ID holds a real instruction.
REQ-011 SHALL have port ifid_pc, output, 32 bits: PC of the held instruction.
REQ-012 SHALL have port ifid_pc_plus4, output, 32 bits: ifid_pc + 4, modulo 2^32.
REQ-013 SHALL have port ifid_instr, output, 32 bits: held instruction word.

Function
REQ-014 SHALL hold three registers: pc_q (next address to issue), the in-flight pair fpc_q/fvalid_q (address issued last cycle), and the IF/ID register (valid, pc, instr).
REQ-015 SHALL drive rom_addr combinationally as fpc_q when stall=1 and redirect_valid=0, else pc_q, so the ROM re-reads the in-flight address while stalled.
REQ-016 Normal cycle (stall=0, redirect_valid=0) SHALL apply all of: pc_q <= pc_q+4; fpc_q <= pc_q; fvalid_q <= 1; IF/ID <= {fvalid_q, fpc_q, rom_instr}.
REQ-017 Stall cycle (stall=1, redirect_valid=0) SHALL leave pc_q, fpc_q, fvalid_q and IF/ID unchanged.
REQ-018 Redirect cycle SHALL apply all of: pc_q <= {redirect_pc[31:2],2'b00}; fvalid_q <= 0; IF/ID valid <= 0; ifid_instr <= NOP_INSTR.
REQ-019 Redirect SHALL take priority over stall when both are asserted in the same cycle.
REQ-020 When IF/ID valid is 0, ifid_instr SHALL equal NOP_INSTR regardless of rom_instr.
REQ-021 PC increment SHALL wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000; no error is flagged.
REQ-022 Redirect target bits [1:0] SHALL be forced to 0; misalignment is silently ignored.
REQ-023 Latency: the first valid IF/ID entry SHALL appear 2 cycles after reset deasserts; after a redirect, the target instruction SHALL reach IF/ID 2 unstalled cycles later.
REQ-024 Steady-state throughput with no stalls or redirects SHALL be one instruction per cycle.

Reset
REQ-025 On reset=1 at a rising edge: pc_q <= RESET_PC, fpc_q <= RESET_PC, fvalid_q <= 0, ifid_valid <= 0, ifid_pc <= 0, ifid_instr <= NOP_INSTR.
REQ-026 Reset SHALL override stall and redirect_valid.
REQ-027 Reset asserted mid-stream SHALL discard the in-flight fetch; no instruction issued before reset may appear valid after it.

Structure
REQ-028 A shared package SHALL hold: the NOP_INSTR constant, the default RESET_PC, the INSTR_BYTES=4 increment, and the 32-bit address/word widths.
REQ-029 A single sub-module if_pc_unit SHALL contain pc_q, the next-PC mux (reset > redirect > stall > +4) and the rom_addr mux.
REQ-030 The in-flight and IF/ID registers SHALL live in if_stage.

Verification
REQ-031 Sequential run: release reset with a ROM word at byte address a = 32'h1000_0000+a -> ifid sequence (pc 0, 4, 8) carries those words; first ifid_valid=1 on cycle 2.
REQ-032 Stall: assert stall for 3 cycles while ifid_pc=8 -> ifid_pc and ifid_instr stay constant; rom_addr=fpc_q. After release, pc 12 follows with no skip or duplicate.
REQ-033 Redirect: redirect_valid=1, redirect_pc=32'h0000_0031 while ifid_pc=8 -> next cycle ifid_valid=0 and ifid_instr=NOP_INSTR; two cycles later ifid_pc=32'h30; pc 12 never appears.
REQ-034 Redirect together with stall -> redirect wins; behaviour identical to REQ-033.
REQ-035 Wrap: redirect to 32'hFFFF_FFFC -> subsequent ifid_pc values are FFFF_FFFC then 0000_0000, with ifid_pc_plus4=0 for the first.
REQ-036 Reset mid-stream with stall=1 -> next cycle ifid_valid=0 and rom_addr=RESET_PC; valid resumes 2 cycles after deassert.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared constants for the instruction-fetch stage.
//   ADDR_W / WORD_W     : byte-address and instruction-word widths
//   INSTR_BYTES         : PC increment per sequential fetch
//   RESET_PC_DEFAULT    : default PC loaded on reset
//   NOP_INSTR_DEFAULT   : default word shown when IF/ID holds no instruction
//   pc_sel_e            : next-PC source select, in priority order
package if_stage_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned WORD_W = 32;

  localparam logic [ADDR_W-1:0] INSTR_BYTES       = 32'd4;
  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [WORD_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    PC_SEL_RESET    = 2'd0,
    PC_SEL_REDIRECT = 2'd1,
    PC_SEL_HOLD     = 2'd2,
    PC_SEL_INC      = 2'd3
  } pc_sel_e;

  // Targets are word aligned; low address bits are dropped silently.
  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_pc_unit.sv
// Program counter and ROM address selection for the fetch stage.
//   clock, reset        : clock, synchronous active-high reset
//   stall               : hold the PC (decode not accepting)
//   redirect_valid/_pc  : taken branch/jump target from a later stage
//   fpc                 : address issued last cycle (in-flight fetch)
//   pc                  : next address to issue (pc_q)
//   rom_addr            : address presented to the synchronous ROM
module if_pc_unit
  import if_stage_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic [ADDR_W-1:0] fpc,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] rom_addr
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  pc_sel_e           pc_sel;

  // Priority: reset > redirect > stall > sequential increment.
  always_comb begin
    pc_sel = PC_SEL_INC;
    if (reset) begin
      pc_sel = PC_SEL_RESET;
    end else if (redirect_valid) begin
      pc_sel = PC_SEL_REDIRECT;
    end else if (stall) begin
      pc_sel = PC_SEL_HOLD;
    end
  end

  always_comb begin
    pc_d = pc_q + INSTR_BYTES;
    unique case (pc_sel)
      PC_SEL_RESET:    pc_d = RESET_PC;
      PC_SEL_REDIRECT: pc_d = align_word(redirect_pc);
      PC_SEL_HOLD:     pc_d = pc_q;
      PC_SEL_INC:      pc_d = pc_q + INSTR_BYTES;
      default:         pc_d = pc_q + INSTR_BYTES;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // While stalled the ROM re-reads the in-flight address so its data
  // output still belongs to fpc when the stall releases.
  always_comb begin
    rom_addr = pc_q;
    if (stall && !redirect_valid) begin
      rom_addr = fpc;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage with a one-cycle synchronous instruction ROM.
//   clock, reset          : clock, synchronous active-high reset
//   stall                 : decode cannot accept; hold PC and IF/ID
//   redirect_valid/_pc    : taken branch/jump target (wins over stall)
//   rom_addr / rom_instr  : ROM address out, ROM data in (one cycle later)
//   ifid_valid/_pc/_pc_plus4/_instr : IF/ID pipeline register outputs
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WORD_W-1:0] rom_instr,
  output logic              ifid_valid,
  output logic [ADDR_W-1:0] ifid_pc,
  output logic [ADDR_W-1:0] ifid_pc_plus4,
  output logic [WORD_W-1:0] ifid_instr
);

  logic [ADDR_W-1:0] pc;

  logic [ADDR_W-1:0] fpc_q,        fpc_d;
  logic              fvalid_q,     fvalid_d;
  logic              ifid_valid_q, ifid_valid_d;
  logic [ADDR_W-1:0] ifid_pc_q,    ifid_pc_d;
  logic [WORD_W-1:0] ifid_instr_q, ifid_instr_d;

  if_pc_unit #(
    .RESET_PC (RESET_PC)
  ) u_pc_unit (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fpc            (fpc_q),
    .pc             (pc),
    .rom_addr       (rom_addr)
  );

  always_comb begin
    fpc_d        = fpc_q;
    fvalid_d     = fvalid_q;
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    if (reset) begin
      fpc_d        = RESET_PC;
      fvalid_d     = 1'b0;
      ifid_valid_d = 1'b0;
      ifid_pc_d    = '0;
      ifid_instr_d = NOP_INSTR;
    end else if (redirect_valid) begin
      // Squash both the in-flight fetch and the IF/ID entry.
      fvalid_d     = 1'b0;
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
    end else if (!stall) begin
      fpc_d        = pc;
      fvalid_d     = 1'b1;
      ifid_valid_d = fvalid_q;
      ifid_pc_d    = fpc_q;
      ifid_instr_d = fvalid_q ? rom_instr : NOP_INSTR;
    end
  end

  always_ff @(posedge clock) begin
    fpc_q        <= fpc_d;
    fvalid_q     <= fvalid_d;
    ifid_valid_q <= ifid_valid_d;
    ifid_pc_q    <= ifid_pc_d;
    ifid_instr_q <= ifid_instr_d;
  end

  assign ifid_valid    = ifid_valid_q;
  assign ifid_pc       = ifid_pc_q;
  assign ifid_pc_plus4 = ifid_pc_q + INSTR_BYTES;
  assign ifid_instr    = ifid_instr_q;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [31:0] ROM_BASE = 32'h1000_0000;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] rom_addr;
  logic [31:0] rom_instr;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic [31:0] ifid_instr;

  int checks   = 0;
  int failures = 0;

  if_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .rom_addr       (rom_addr),
    .rom_instr      (rom_instr),
    .ifid_valid     (ifid_valid),
    .ifid_pc        (ifid_pc),
    .ifid_pc_plus4  (ifid_pc_plus4),
    .ifid_instr     (ifid_instr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous ROM: word at byte address a is ROM_BASE + a.
  always @(posedge clock) rom_instr <= ROM_BASE + rom_addr;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        chk_addr;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic        chk_pc;
  } vec_t;

  typedef struct {
    int          step;
    logic        valid;
    logic [31:0] pc;
    logic        chk_pc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic void add(input logic rst, input logic st, input logic rv,
                              input logic [31:0] rpc, input logic chk_addr,
                              input logic [31:0] addr, input logic valid,
                              input logic [31:0] pc);
    vec_t v;
    v.rst = rst; v.stall = st; v.rv = rv; v.rpc = rpc;
    v.chk_addr = chk_addr; v.addr = addr;
    v.valid = valid; v.pc = pc; v.chk_pc = valid | rst;
    vecs.push_back(v);
  endfunction

  task automatic check32(input string name, input int step,
                         input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d got %h want %h", name, step, act, exp);
    end
  endtask

  // Pops the oldest expectation and compares it with the IF/ID outputs.
  task automatic compare_outputs();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty step - got 0 want 1");
      return;
    end
    e = sb.pop_front();
    check32("ifid_valid", e.step, {31'b0, ifid_valid}, {31'b0, e.valid});
    if (e.chk_pc) begin
      check32("ifid_pc", e.step, ifid_pc, e.pc);
      check32("ifid_pc_plus4", e.step, ifid_pc_plus4, e.pc + 32'd4);
    end
    check32("ifid_instr", e.step, ifid_instr, e.valid ? (ROM_BASE + e.pc) : NOP);
  endtask

  task automatic run_to_pc8();
    add(1, 0, 0, 0, 0, 0,  0, 0);
    add(1, 0, 0, 0, 1, 0,  0, 0);
    add(0, 0, 0, 0, 1, 0,  0, 0);
    add(0, 0, 0, 0, 1, 4,  1, 0);   // first valid entry, 2 cycles after reset
    add(0, 0, 0, 0, 1, 8,  1, 4);
    add(0, 0, 0, 0, 1, 12, 1, 8);   // now pc=16, fpc=12, ifid_pc=8
  endtask

  initial begin
    exp_t e;
    reset = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;

    // Sequential run then redirect to a misaligned target.
    run_to_pc8();
    add(0, 0, 1, 32'h0000_0031, 1, 16,   0, 0);
    add(0, 0, 0, 0,             1, 32'h30, 0, 0);
    add(0, 0, 0, 0,             1, 32'h34, 1, 32'h30);
    add(0, 0, 0, 0,             1, 32'h38, 1, 32'h34);

    // Stall for three cycles holding ifid_pc=8.
    run_to_pc8();
    add(0, 1, 0, 0, 1, 12, 1, 8);
    add(0, 1, 0, 0, 1, 12, 1, 8);
    add(0, 1, 0, 0, 1, 12, 1, 8);
    add(0, 0, 0, 0, 1, 16, 1, 12);
    add(0, 0, 0, 0, 1, 20, 1, 16);

    // Redirect together with stall: redirect wins.
    run_to_pc8();
    add(0, 1, 1, 32'h0000_0031, 1, 16,   0, 0);
    add(0, 0, 0, 0,             1, 32'h30, 0, 0);
    add(0, 0, 0, 0,             1, 32'h34, 1, 32'h30);
    add(0, 0, 0, 0,             1, 32'h38, 1, 32'h34);

    // Wrap: redirect near the top of the address space.
    add(0, 0, 1, 32'hFFFF_FFFE, 1, 32'h3C,        0, 0);
    add(0, 0, 0, 0,             1, 32'hFFFF_FFFC, 0, 0);
    add(0, 0, 0, 0,             1, 32'h0,         1, 32'hFFFF_FFFC);
    add(0, 0, 0, 0,             1, 32'h4,         1, 32'h0);

    // Mid-stream reset with stall asserted.
    add(1, 1, 0, 0, 1, 32'h4, 0, 0);
    add(0, 0, 0, 0, 1, 32'h0, 0, 0);
    add(0, 0, 0, 0, 1, 32'h4, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      reset          = vecs[i].rst;
      stall          = vecs[i].stall;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      e.step = i; e.valid = vecs[i].valid; e.pc = vecs[i].pc; e.chk_pc = vecs[i].chk_pc;
      sb.push_back(e);
      #1;
      if (vecs[i].chk_addr) check32("rom_addr", i, rom_addr, vecs[i].addr);
      @(posedge clock);
      #1;
      compare_outputs();
    end

    // Steady-state throughput: one new instruction per cycle.
    reset = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    for (int unsigned k = 1; k <= 20; k++) begin
      e.step = 1000 + int'(k); e.valid = 1'b1; e.pc = 32'(4 * k); e.chk_pc = 1'b1;
      sb.push_back(e);
      @(posedge clock);
      #1;
      compare_outputs();
    end

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d want 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
